adder_share_ctrl: RTL and testbench
===================================

# adder_share_ctrl

Round-robin controller that time-shares the single combinational 12-bit Brent-Kung adder among `NREQ` requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and drives the adder's interleaved 24-bit input. It registers the 13-bit result and returns it on one shared response port tagged with the requester id. It sits between client datapaths and the adder instance; the adder itself stays outside this block.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`: width of the response id.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  NREQ*12  operand A, requester i at bits [12i+11:12i].
- `req_b`  in  NREQ*12  operand B, same packing as `req_a`.
- `req_last`  in  NREQ  last word of a chained operation; present only with `ADDSHARE_CHAIN_EN`.
- `add_in`  out  24  adder input; bit 2k = A[k], bit 2k+1 = B[k].
- `add_out`  in  13  adder sum; bit 12 is carry-out.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_sum`  out  13  registered sum; bit 12 is carry.
- `rsp_id`  out  IDW  index of the requester that owns the response.

## Operation

- FSM states: IDLE, EXEC, RESP, plus INC when `ADDSHARE_CHAIN_EN` is defined.
- Grant selection:
  - Round-robin from pointer `ptr`; the grant goes to the first requester at or after `ptr` with `req_valid` set.
  - `req_ready[g]` is high only for that requester, and only in IDLE, or in RESP when `rsp_ready` is high.
  - On accept, operands and id are captured, `ptr` becomes g+1 mod NREQ, and the FSM goes to EXEC.
- EXEC:
  - `add_in` is driven from the operand registers.
  - `add_out` is captured into `rsp_sum`.
  - Next state is RESP.
- RESP:
  - `rsp_valid` is high and `rsp_sum`/`rsp_id` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake, if a new request is accepted in the same cycle, the FSM goes to EXEC; otherwise it goes to IDLE.
- Outside EXEC and INC, `add_in` is driven to 0.
- A requester that drops `req_valid` before it is granted loses nothing; `ptr` does not move.
- Reset values: state IDLE, `ptr` 0, `rsp_valid` 0, `rsp_sum` 0, `rsp_id` 0, `req_ready` all 0, `add_in` 0.
- Reset asserted mid-operation discards any in-flight operand or response; nothing is replayed.

## Timing

- Accept at edge k → EXEC in cycle k+1 → `rsp_valid` high after edge k+2. Minimum latency is 2 cycles.
- Back-to-back: with `rsp_ready` held high, one result every 2 cycles.
- `req_ready` depends combinationally on `req_valid`, `ptr`, state and `rsp_ready`. No output depends combinationally on `add_out`.

## Configuration

`ADDSHARE_CHAIN_EN` enables multi-word additions.

Defined:
- `req_last` port exists, and a carry register `cy` exists (reset 0).
- Grant lock: while a chain is open (a word with `req_last`=0 was accepted), only the locked requester is granted, and `ptr` does not advance until its last word is accepted.
- Carry-in handling: in EXEC, if `cy`=1, the sum is captured and the FSM goes to INC. INC drives `add_in` with A=captured sum[11:0], B=1. The response carry is `sum1[12] | sum2[12]`.
- After each word's response, `cy` takes that carry, then clears when the `req_last` word completes.
- Latency is 3 cycles when a carry-in is applied.

Undefined:
- No `req_last`, `cy`, lock or INC.
- Every request is an independent 12-bit add.

## Structure

- Shared package `addshare_pkg`:
  - state enum `addshare_state_e`;
  - constants `ADD_W`=12 and `ADD_IN_W`=24;
  - function `pack_operands(a,b)` that produces the interleaved 24-bit word.
- One sub-module, `rr_arbiter #(NREQ)`: inputs are the request vector, `ptr` and a lock mask; output is a one-hot grant. It is purely combinational.
- The adder is not instantiated here; the parent connects `add_in`/`add_out` to it.

## Test plan

- Single request: req0 A=0x001, B=0xFFF, `rsp_ready`=1 → after 2 cycles `rsp_sum`=0x1000, `rsp_id`=0.
- All four requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0; one response every 2 cycles; ids in that order.
- Response backpressure: `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_sum` and `rsp_id` held stable; no `req_ready` asserted; accept occurs in the release cycle.
- Reset in EXEC with req2 pending → next cycle state IDLE, `rsp_valid`=0, `ptr`=0; first grant after reset goes to req0 if it is valid.
- Chain (`ADDSHARE_CHAIN_EN`), req1:
  - word0 A=0xFFF, B=0x001 (last=0), word1 A=0x000, B=0x000 (last=1), req0 valid throughout;
  - responses are 0x1000, then 0x001 via INC;
  - req0 is not granted until after word1 is accepted.
- Chain carry through INC: A=0xFFF, B=0x000, `cy`=1 → `rsp_sum`=0x1000; `cy` stays 1 if last=0.

Source files
------------

// File: rtl/addshare_pkg.sv
// Shared types and helpers for the adder-sharing controller.
// ADDSHARE_CHAIN_EN adds the INC state for multi-word carry chains.
package addshare_pkg;

   localparam int ADD_W    = 12;
   localparam int ADD_IN_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
`ifdef ADDSHARE_CHAIN_EN
      ,
      ST_INC  = 2'd3
`endif
   } addshare_state_e;

   // The adder takes A and B bit-interleaved: bit 2k = A[k], 2k+1 = B[k].
   function automatic logic [ADD_IN_W-1:0] pack_operands(
      input logic [ADD_W-1:0] a,
      input logic [ADD_W-1:0] b
   );
      logic [ADD_IN_W-1:0] w;
      for (int k = 0; k < ADD_W; k++) begin
         w[2*k]   = a[k];
         w[2*k+1] = b[k];
      end
      return w;
   endfunction

endpackage

// File: rtl/adder_share_ctrl_arb.sv
// Round-robin one-hot grant: first eligible requester at or after ptr.
// Combinational only; mask restricts grants while a chain is locked.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic [NREQ-1:0] mask,
   output logic [NREQ-1:0] gnt
);

   logic [NREQ-1:0] elig;
   logic            found;

   assign elig = req & mask;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && elig[j] && j >= int'(ptr)) begin
            gnt[j] = 1'b1;
            found  = 1'b1;
         end
      end
      // wrap around to the requesters below ptr
      for (int j = 0; j < NREQ; j++) begin
         if (!found && elig[j] && j < int'(ptr)) begin
            gnt[j] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one external 12-bit adder among NREQ requesters.
// Define ADDSHARE_CHAIN_EN for multi-word adds with carry and grant lock.
module adder_share_ctrl
   import addshare_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*ADD_W-1:0] req_a,
   input  logic [NREQ*ADD_W-1:0] req_b,
`ifdef ADDSHARE_CHAIN_EN
   input  logic [NREQ-1:0]       req_last,
`endif
   output logic [ADD_IN_W-1:0]   add_in,
   input  logic [ADD_W:0]        add_out,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ADD_W:0]        rsp_sum,
   output logic [IDW-1:0]        rsp_id
);

   addshare_state_e state, state_n;

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_nxt;
   logic [IDW-1:0]   g_idx;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  mask;
   logic [ADD_W-1:0] a_q, b_q;
   logic [ADD_W-1:0] a_sel, b_sel;
   logic             hs;
   logic             accept_en;
   logic             accept;
   logic             ptr_adv;

   rr_arbiter #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .mask(mask),
      .gnt (gnt)
   );

   always_comb begin
      g_idx = '0;
      a_sel = '0;
      b_sel = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt[j]) begin
            g_idx = IDW'(j);
            a_sel = req_a[j*ADD_W +: ADD_W];
            b_sel = req_b[j*ADD_W +: ADD_W];
         end
      end
   end

   assign ptr_nxt   = (g_idx == IDW'(NREQ-1)) ? '0 : g_idx + 1'b1;
   assign hs        = (state == ST_RESP) && rsp_ready;
   assign accept_en = (state == ST_IDLE) || hs;
   assign req_ready = accept_en ? gnt : '0;
   assign accept    = |req_ready;
   assign rsp_valid = (state == ST_RESP);

`ifdef ADDSHARE_CHAIN_EN
   logic           cy;
   logic           last_q;
   logic           lock_q;
   logic [IDW-1:0] lock_id;
   logic           last_sel;

   always_comb begin
      last_sel = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt[j]) last_sel = req_last[j];
      end
   end

   assign mask    = lock_q ? (NREQ'(1) << lock_id) : {NREQ{1'b1}};
   assign ptr_adv = last_sel;

   // carry follows each word's response and clears once the chain ends
   always_ff @(posedge clk) begin
      if (rst) begin
         cy      <= 1'b0;
         last_q  <= 1'b0;
         lock_q  <= 1'b0;
         lock_id <= '0;
      end else begin
         if (hs) cy <= last_q ? 1'b0 : rsp_sum[ADD_W];
         if (accept) begin
            last_q  <= last_sel;
            lock_q  <= !last_sel;
            lock_id <= g_idx;
         end
      end
   end
`else
   assign mask    = {NREQ{1'b1}};
   assign ptr_adv = 1'b1;
`endif

   always_comb begin
      state_n = state;
      add_in  = '0;
      unique case (state)
         ST_IDLE: begin
            if (accept) state_n = ST_EXEC;
         end
         ST_EXEC: begin
            add_in = pack_operands(a_q, b_q);
`ifdef ADDSHARE_CHAIN_EN
            state_n = cy ? ST_INC : ST_RESP;
`else
            state_n = ST_RESP;
`endif
         end
`ifdef ADDSHARE_CHAIN_EN
         ST_INC: begin
            add_in  = pack_operands(rsp_sum[ADD_W-1:0], ADD_W'(1));
            state_n = ST_RESP;
         end
`endif
         ST_RESP: begin
            if (rsp_ready) state_n = accept ? ST_EXEC : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rsp_sum <= '0;
         rsp_id  <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            rsp_id <= g_idx;
            if (ptr_adv) ptr <= ptr_nxt;
         end
         if (state == ST_EXEC) rsp_sum <= add_out;
`ifdef ADDSHARE_CHAIN_EN
         if (state == ST_INC) begin
            rsp_sum <= {rsp_sum[ADD_W] | add_out[ADD_W],
                        add_out[ADD_W-1:0]};
         end
`endif
      end
   end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized bench for adder_share_ctrl against a transaction-level model.
// Chain scenarios are exercised when ADDSHARE_CHAIN_EN is defined.
module tb_adder_share_ctrl;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*12-1:0]  req_a;
   logic [NREQ*12-1:0]  req_b;
`ifdef ADDSHARE_CHAIN_EN
   logic [NREQ-1:0]     req_last;
`endif
   logic [23:0]         add_in;
   logic [12:0]         add_out;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [12:0]         rsp_sum;
   logic [IDW-1:0]      rsp_id;

   int n_checks = 0;
   int n_err    = 0;

   int a_in[NREQ];
   int b_in[NREQ];
   bit last_in[NREQ];

   // model of the outstanding transaction
   int t = 0;
   int ptr = 0;
   bit busy = 0;
   int op_a, op_b, op_id, op_t, op_cin, op_sum;
   bit op_last;
   int cy = 0;
   bit lock_open = 0;
   int lock_id = 0;
   int gnt_log[$];
   int rsp_log[$];

   always #5 clk = ~clk;

   function automatic int lane(input logic [23:0] w, input int sel);
      int v = 0;
      for (int k = 0; k < 12; k++) if (w[2*k+sel]) v += (1 << k);
      return v;
   endfunction

   function automatic logic [23:0] weave(input int a, input int b);
      logic [23:0] w = '0;
      for (int k = 0; k < 12; k++) begin
         w[2*k]   = a[k];
         w[2*k+1] = b[k];
      end
      return w;
   endfunction

   // stand-in for the external adder
   assign add_out = 13'(lane(add_in, 0) + lane(add_in, 1));

   adder_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
`ifdef ADDSHARE_CHAIN_EN
      .req_last (req_last),
`endif
      .add_in   (add_in),
      .add_out  (add_out),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_sum  (rsp_sum),
      .rsp_id   (rsp_id)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic [NREQ-1:0] v, input logic rr,
                        input logic r);
      int g = -1;
      bit rv = 0;
      bit can;
      logic [23:0] exp_in;
      @(negedge clk);
      rst       = r;
      req_valid = v;
      rsp_ready = rr;
      for (int j = 0; j < NREQ; j++) begin
         req_a[12*j +: 12] = 12'(a_in[j]);
         req_b[12*j +: 12] = 12'(b_in[j]);
`ifdef ADDSHARE_CHAIN_EN
         req_last[j] = last_in[j];
`endif
      end
      #1;
      if (!r) begin
         rv = busy && (t >= op_t + 2 + op_cin);
         chk("rsp_valid", rsp_valid, rv);
         if (rv) begin
            chk("rsp_sum", rsp_sum, op_sum);
            chk("rsp_id", rsp_id, op_id);
         end
         exp_in = '0;
         if (busy && t == op_t + 1) exp_in = weave(op_a, op_b);
         else if (busy && op_cin != 0 && t == op_t + 2)
            exp_in = weave((op_a + op_b) & 'hFFF, 1);
         chk("add_in", add_in, exp_in);
         can = !busy || (rv && rr);
         if (can) begin
            for (int i = 0; i < NREQ; i++) begin
               int j = (ptr + i) % NREQ;
               if (g < 0 && v[j] && (!lock_open || lock_id == j)) g = j;
            end
         end
         chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      end
      if (r) begin
         busy = 0;
         ptr = 0;
         cy = 0;
         lock_open = 0;
      end else begin
         if (rv && rr) begin
            busy = 0;
            rsp_log.push_back((op_id << 16) | op_sum);
`ifdef ADDSHARE_CHAIN_EN
            cy = op_last ? 0 : (op_sum >> 12);
`endif
         end
         if (g >= 0) begin
            busy = 1;
            op_a = a_in[g];
            op_b = b_in[g];
            op_id = g;
            op_t = t;
            op_cin = cy;
            op_sum = a_in[g] + b_in[g] + cy;
            op_last = last_in[g];
            gnt_log.push_back(g);
`ifdef ADDSHARE_CHAIN_EN
            lock_open = !last_in[g];
            lock_id = g;
            if (last_in[g]) ptr = (g + 1) % NREQ;
`else
            ptr = (g + 1) % NREQ;
`endif
         end
      end
      t++;
   endtask

   task automatic rand_ops();
      for (int j = 0; j < NREQ; j++) begin
         a_in[j] = $urandom_range(0, 4095);
         b_in[j] = $urandom_range(0, 4095);
         last_in[j] = 1'b1;
      end
   endtask

`ifdef ADDSHARE_CHAIN_EN
   task automatic chain_word(input int id, input int a, input int b,
                             input bit last, input logic [NREQ-1:0] other);
      bit got = 0;
      a_in[id] = a;
      b_in[id] = b;
      last_in[id] = last;
      for (int n = 0; n < 20 && !got; n++) begin
         int n0 = gnt_log.size();
         cycle(other | NREQ'(1 << id), 1'b1, 1'b0);
         if (gnt_log.size() > n0 && gnt_log[$] == id) got = 1;
      end
      chk("chain_grant", got, 1);
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a = '0;
      req_b = '0;
`ifdef ADDSHARE_CHAIN_EN
      req_last = '0;
`endif
      rand_ops();
      repeat (2) cycle('0, 1'b1, 1'b1);
      cycle('0, 1'b1, 1'b0);
      chk("reset_sum", rsp_sum, 0);
      chk("reset_id", rsp_id, 0);

      // single request 0x001 + 0xFFF from req0
      a_in[0] = 'h001;
      b_in[0] = 'hFFF;
      cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      chk("single_sum", rsp_sum, 13'h1000);
      chk("single_id", rsp_id, 0);
      cycle(4'b0000, 1'b1, 1'b0);

      // all requesters continuously valid
      cycle('0, 1'b1, 1'b1);
      gnt_log.delete();
      rand_ops();
      repeat (10) cycle(4'b1111, 1'b1, 1'b0);
      chk("rr_count", gnt_log.size() >= 5, 1);
      for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], i % 4);

      // response backpressure then release
      repeat (5) cycle(4'b1111, 1'b0, 1'b0);
      cycle(4'b1111, 1'b1, 1'b0);
      repeat (3) cycle(4'b0000, 1'b1, 1'b0);

      // reset while req2 is in EXEC
      cycle(4'b0100, 1'b1, 1'b0);
      cycle(4'b0100, 1'b1, 1'b1);
      cycle(4'b0101, 1'b0, 1'b0);
      chk("rst_gnt", req_ready, 4'b0001);
      chk("rst_valid", rsp_valid, 0);
      repeat (3) cycle(4'b0000, 1'b1, 1'b0);

`ifdef ADDSHARE_CHAIN_EN
      cycle('0, 1'b1, 1'b1);
      a_in[0] = 0;
      b_in[0] = 0;
      last_in[0] = 1'b1;
      cycle(4'b0001, 1'b1, 1'b0);
      repeat (3) cycle(4'b0000, 1'b1, 1'b0);
      gnt_log.delete();
      rsp_log.delete();
      chain_word(1, 'hFFF, 'h001, 1'b0, 4'b0001);
      chain_word(1, 'h000, 'h000, 1'b1, 4'b0001);
      repeat (6) cycle(4'b0000, 1'b1, 1'b0);
      chk("lock_g0", gnt_log[0], 1);
      chk("lock_g1", gnt_log[1], 1);
      chk("chain_r0", rsp_log[0], (1 << 16) | 'h1000);
      chk("chain_r1", rsp_log[1], (1 << 16) | 'h001);

      rsp_log.delete();
      chain_word(1, 'hFFF, 'h001, 1'b0, 4'b0000);
      chain_word(1, 'hFFF, 'h000, 1'b0, 4'b0000);
      chain_word(1, 'h000, 'h000, 1'b1, 4'b0000);
      repeat (6) cycle(4'b0000, 1'b1, 1'b0);
      chk("inc_r0", rsp_log[0], (1 << 16) | 'h1000);
      chk("inc_r1", rsp_log[1], (1 << 16) | 'h1000);
      chk("inc_r2", rsp_log[2], (1 << 16) | 'h001);
`endif

      // randomized traffic with occasional reset
      for (int n = 0; n < 2000; n++) begin
         rand_ops();
`ifdef ADDSHARE_CHAIN_EN
         for (int j = 0; j < NREQ; j++) last_in[j] = $urandom_range(0, 1) != 0;
`endif
         cycle(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 199) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
